// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and defaults for the audio mode controller
//
// Holds the controller state encoding, the latched playback speed record,
// the default SRAM address width and last writable address, and the helper
// that turns the raw speed switches into a speed record.

package aud_pkg;

  localparam int AUD_ADDR_W = 20;
  localparam logic [AUD_ADDR_W-1:0] AUD_MAX_ADDR = 20'hFFFFF;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_PLAY       = 3'd2,
    S_PLAY_PAUSE = 3'd3,
    S_REC        = 3'd4,
    S_REC_PAUSE  = 3'd5
  } aud_state_t;

  typedef struct packed {
    logic       fast;
    logic       slow_0;
    logic       slow_1;
    logic [2:0] speed;
  } speed_cfg_t;

  // sw[4] = fast, sw[3] = slow linear (else slow constant), sw[2:0] = factor-1.
  // Fast overrides both slow flavours.
  function automatic speed_cfg_t decode_speed(input logic [4:0] sw);
    speed_cfg_t cfg;
    cfg.fast   = sw[4];
    cfg.slow_1 = ~sw[4] & sw[3];
    cfg.slow_0 = ~sw[4] & ~sw[3];
    cfg.speed  = sw[2:0];
    return cfg;
  endfunction

endpackage

// File: rtl/aud_key_edge.sv
// rtl/aud_key_edge.sv - rising-edge detector for one debounced key
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   level in  debounced key level
//   rise  out high in the single cycle where level goes 0 -> 1
//
// The previous level is registered; rise is combinational from it so the
// consuming state machine adds the only register on the command path.

module aud_key_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/aud_mode_ctrl.sv
// rtl/aud_mode_ctrl.sv - record/playback mode controller for the audio path
//
// Optional feature macro: AUD_CTRL_LOOP_EN (end of playback restarts the
// player instead of returning to idle).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_key_play/rec/pause/stop    debounced key levels
//   i_i2c_done                   codec init complete
//   i_rec_addr, i_play_addr      recorder write / player read address
//   i_speed_sw                   raw playback speed switches
//   o_i2c_start                  one-cycle codec init pulse
//   o_dsp_start/pause/stop       one-cycle player commands
//   o_rec_start/pause/stop       one-cycle recorder commands
//   o_sram_sel                   1 while the recorder owns the SRAM
//   o_end_addr                   end address of the last recording
//   o_fast, o_slow_0, o_slow_1, o_speed  latched speed configuration
//   o_state                      current state encoding

import aud_pkg::*;

module aud_mode_ctrl #(
  parameter int                ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = AUD_MAX_ADDR
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_play,
  input  logic              i_key_rec,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_i2c_done,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  input  logic [4:0]        i_speed_sw,
  output logic              o_i2c_start,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_sram_sel,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_fast,
  output logic              o_slow_0,
  output logic              o_slow_1,
  output logic [2:0]        o_speed,
  output logic [2:0]        o_state
);

  logic play_rise, rec_rise, pause_rise, stop_rise;

  aud_key_edge u_edge_play  (.clk(i_clk), .rst(i_rst), .level(i_key_play),  .rise(play_rise));
  aud_key_edge u_edge_rec   (.clk(i_clk), .rst(i_rst), .level(i_key_rec),   .rise(rec_rise));
  aud_key_edge u_edge_pause (.clk(i_clk), .rst(i_rst), .level(i_key_pause), .rise(pause_rise));
  aud_key_edge u_edge_stop  (.clk(i_clk), .rst(i_rst), .level(i_key_stop),  .rise(stop_rise));

  aud_state_t state;
  speed_cfg_t spd;
  logic       init_sent;   // codec init pulse already issued since reset
`ifdef AUD_CTRL_LOOP_EN
  logic       loop_pend;   // end of play hit last cycle; restart the player now
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_INIT;
      init_sent   <= 1'b0;
      o_i2c_start <= 1'b0;
      o_dsp_start <= 1'b0;
      o_dsp_pause <= 1'b0;
      o_dsp_stop  <= 1'b0;
      o_rec_start <= 1'b0;
      o_rec_pause <= 1'b0;
      o_rec_stop  <= 1'b0;
      o_sram_sel  <= 1'b0;
      o_end_addr  <= '0;
      spd         <= '0;
`ifdef AUD_CTRL_LOOP_EN
      loop_pend   <= 1'b0;
`endif
    end else begin
      // Commands are strobes: cleared every cycle unless a branch raises one.
      o_i2c_start <= 1'b0;
      o_dsp_start <= 1'b0;
      o_dsp_pause <= 1'b0;
      o_dsp_stop  <= 1'b0;
      o_rec_start <= 1'b0;
      o_rec_pause <= 1'b0;
      o_rec_stop  <= 1'b0;
`ifdef AUD_CTRL_LOOP_EN
      loop_pend   <= 1'b0;
`endif
      case (state)
        S_INIT: begin
          // The done check waits for the pulse so a done level left high
          // across reset still sees a fresh init request first.
          if (!init_sent) begin
            o_i2c_start <= 1'b1;
            init_sent   <= 1'b1;
          end else if (i_i2c_done) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (play_rise) begin
            spd         <= decode_speed(i_speed_sw);
            o_dsp_start <= 1'b1;
            state       <= S_PLAY;
          end else if (rec_rise) begin
            o_rec_start <= 1'b1;
            o_sram_sel  <= 1'b1;
            state       <= S_REC;
          end
        end
        S_PLAY: begin
          if (stop_rise) begin
            o_dsp_stop <= 1'b1;
            state      <= S_IDLE;
          end else if (pause_rise) begin
            o_dsp_pause <= 1'b1;
            state       <= S_PLAY_PAUSE;
`ifdef AUD_CTRL_LOOP_EN
          end else if (loop_pend) begin
            o_dsp_start <= 1'b1;
          end else if (i_play_addr >= o_end_addr) begin
            o_dsp_stop <= 1'b1;
            loop_pend  <= 1'b1;
`else
          end else if (i_play_addr >= o_end_addr) begin
            o_dsp_stop <= 1'b1;
            state      <= S_IDLE;
`endif
          end
        end
        S_PLAY_PAUSE: begin
          if (stop_rise) begin
            o_dsp_stop <= 1'b1;
            state      <= S_IDLE;
          end else if (play_rise) begin
            spd         <= decode_speed(i_speed_sw);
            o_dsp_start <= 1'b1;
            state       <= S_PLAY;
          end
        end
        S_REC: begin
          // Hitting the last SRAM word ends the recording exactly like stop.
          if (stop_rise || (i_rec_addr == MAX_ADDR)) begin
            o_rec_stop <= 1'b1;
            o_end_addr <= i_rec_addr;
            o_sram_sel <= 1'b0;
            state      <= S_IDLE;
          end else if (pause_rise) begin
            o_rec_pause <= 1'b1;
            state       <= S_REC_PAUSE;
          end
        end
        S_REC_PAUSE: begin
          if (stop_rise) begin
            o_rec_stop <= 1'b1;
            o_end_addr <= i_rec_addr;
            o_sram_sel <= 1'b0;
            state      <= S_IDLE;
          end else if (rec_rise) begin
            o_rec_start <= 1'b1;
            state       <= S_REC;
          end
        end
        default: begin
          o_sram_sel <= 1'b0;
          state      <= S_INIT;
        end
      endcase
    end
  end

  assign o_fast   = spd.fast;
  assign o_slow_0 = spd.slow_0;
  assign o_slow_1 = spd.slow_1;
  assign o_speed  = spd.speed;
  assign o_state  = state;

endmodule
